// File: rtl/avm_pkg.sv
// Shared types and widths for the Avalon-MM initiator.
package avm_pkg;

   localparam int AVM_ADDR_W = 32;
   localparam int AVM_DATA_W = 32;
   localparam int AVM_BE_W   = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      GAP    = 2'd2
   } avm_state_t;

   // The responder is word addressed, so the two byte-offset bits are dropped.
   function automatic logic [AVM_ADDR_W-1:0] word_align(input logic [AVM_ADDR_W-1:0] addr);
      return {addr[AVM_ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/avm_timeout_counter.sv
// Stall counter for the Avalon initiator; flags expiry after TIMEOUT_CYCLES-1 stalled cycles.
module avm_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/avalon_mm_master.sv
// Avalon-MM initiator: one core request at a time, idle cycle between transfers.
// Optional transfer timeout enabled by defining AVM_TIMEOUT_EN.
module avalon_mm_master
   import avm_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [AVM_ADDR_W-1:0] req_addr,
   input  logic [AVM_BE_W-1:0]   req_byteenable,
   input  logic [AVM_DATA_W-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [AVM_DATA_W-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic [AVM_ADDR_W-1:0] address,
   output logic [AVM_BE_W-1:0]   byteenable,
   output logic                  read,
   output logic                  write,
   output logic [AVM_DATA_W-1:0] writedata,
   input  logic                  waitrequest,
   input  logic [AVM_DATA_W-1:0] readdata
);

   avm_state_t state, state_next;
   logic       accept;
   logic       complete;
   logic       abandon;
   logic       expired;
   logic       unused_addr_lsb;

   assign unused_addr_lsb = ^req_addr[1:0];
   assign req_ready       = (state == IDLE) && !reset;

`ifdef AVM_TIMEOUT_EN
   avm_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (accept),
      .inc     ((state == ACCESS) && waitrequest),
      .expired (expired)
   );
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign expired   = 1'b0;
   assign rsp_error = 1'b0;
`endif

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      complete   = 1'b0;
      abandon    = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept     = 1'b1;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            if (!waitrequest) begin
               complete   = 1'b1;
               state_next = GAP;
            end else if (expired) begin
               abandon    = 1'b1;
               state_next = GAP;
            end
         end
         GAP:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         read       <= 1'b0;
         write      <= 1'b0;
         address    <= '0;
         byteenable <= '0;
         writedata  <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         state     <= state_next;
         rsp_valid <= complete || abandon;
         if (accept) begin
            address    <= word_align(req_addr);
            byteenable <= req_byteenable;
            writedata  <= req_wdata;
            read       <= ~req_write;
            write      <= req_write;
         end
         if (complete || abandon) begin
            read  <= 1'b0;
            write <= 1'b0;
         end
         // read is still high on the completion edge, so it marks a read transfer.
         if (complete && read) begin
            rsp_rdata <= readdata;
         end
      end
   end

`ifdef AVM_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_error <= 1'b0;
      end else if (abandon) begin
         rsp_error <= 1'b1;
      end else if (complete) begin
         rsp_error <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_avalon_mm_master.sv
// Directed self-checking bench for avalon_mm_master with a small word-addressed responder model.
module tb_avalon_mm_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [3:0]  req_byteenable = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic [31:0] address;
   logic [3:0]  byteenable;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic        waitrequest = 1'b0;
   logic [31:0] readdata = '0;

   int total = 0;
   int bad = 0;

   logic [31:0] mem [0:63];
   int          wait_cfg = 0;
   int          cnt = 0;
   bit          busy = 1'b0;
   bit          stuck = 1'b0;

   avalon_mm_master #(.TIMEOUT_CYCLES(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_byteenable (req_byteenable),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_error      (rsp_error),
      .address        (address),
      .byteenable     (byteenable),
      .read           (read),
      .write          (write),
      .writedata      (writedata),
      .waitrequest    (waitrequest),
      .readdata       (readdata)
   );

   always #5 clk = ~clk;

   // Responder: stalls wait_cfg cycles per transfer, updated away from the active edge.
   always @(negedge clk) begin
      if (stuck) begin
         waitrequest = 1'b1;
      end else if (!(read || write)) begin
         busy = 1'b0;
         waitrequest = 1'b0;
      end else if (!busy) begin
         busy = 1'b1;
         cnt = wait_cfg;
         waitrequest = (cnt > 0);
      end else begin
         if (cnt > 0) cnt = cnt - 1;
         waitrequest = (cnt > 0);
      end
      readdata = mem[address[7:2]];
   end

   always @(posedge clk) begin
      if (!reset && write && !waitrequest) begin
         for (int b = 0; b < 4; b++)
            if (byteenable[b]) mem[address[7:2]][8*b +: 8] = writedata[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      req_valid = 1'b1;
      req_write = wr;
      req_addr = a;
      req_byteenable = be;
      req_wdata = d;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("rsp_within_bound", {31'd0, rsp_valid}, 32'd1);
   endtask

   task automatic gap_done();
      tick();
      chk("gap_rsp_valid_low", {31'd0, rsp_valid}, 32'd0);
      chk("gap_then_ready", {31'd0, req_ready}, 32'd1);
   endtask

   // {read, write, rsp_valid, req_ready} per cycle after the first accept, waitrequest=0.
   logic [3:0] b2b_exp [0:5];
   logic [31:0] saved;
   int n;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0101_0101 * i;
      mem[1] = 32'h2402_000A;
      b2b_exp[0] = 4'b1000; b2b_exp[1] = 4'b0010; b2b_exp[2] = 4'b0001;
      b2b_exp[3] = 4'b1000; b2b_exp[4] = 4'b0010; b2b_exp[5] = 4'b0001;

      // reset state
      tick(); tick();
      chk("rst_read", {31'd0, read}, 32'd0);
      chk("rst_write", {31'd0, write}, 32'd0);
      chk("rst_address", address, 32'd0);
      chk("rst_byteenable", {28'd0, byteenable}, 32'd0);
      chk("rst_writedata", writedata, 32'd0);
      chk("rst_rsp", {29'd0, rsp_valid, rsp_error, req_ready}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      reset = 1'b0;
      tick();
      chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

      // single-cycle read
      wait_cfg = 0;
      issue(1'b0, 32'hBFC0_0004, 4'hF, 32'd0);
      chk("rd_read_high", {30'd0, read, write}, 32'd2);
      chk("rd_address", address, 32'hBFC0_0004);
      chk("rd_not_ready", {31'd0, req_ready}, 32'd0);
      wait_rsp(n);
      chk("rd_latency", n, 32'd1);
      chk("rd_rdata", rsp_rdata, 32'h2402_000A);
      chk("rd_read_dropped", {31'd0, read}, 32'd0);
      chk("rd_error", {31'd0, rsp_error}, 32'd0);
      gap_done();

      // write with 5 stall cycles
      wait_cfg = 5;
      issue(1'b1, 32'hBFC0_0010, 4'hF, 32'hDEAD_BEEF);
      chk("wr_write_high", {30'd0, read, write}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("wr_stall_ctrl", {29'd0, read, write, rsp_valid}, 32'd2);
         chk("wr_stall_addr", address, 32'hBFC0_0010);
         chk("wr_stall_data", writedata, 32'hDEAD_BEEF);
      end
      tick();
      chk("wr_rsp_after_stall", {29'd0, read, write, rsp_valid}, 32'd1);
      chk("wr_rdata_held", rsp_rdata, 32'h2402_000A);
      gap_done();

      // read back the written word
      wait_cfg = 0;
      issue(1'b0, 32'hBFC0_0010, 4'hF, 32'd0);
      wait_rsp(n);
      chk("rdback_data", rsp_rdata, 32'hDEAD_BEEF);
      gap_done();

      // unaligned address
      issue(1'b0, 32'hBFC0_0007, 4'b1000, 32'd0);
      chk("unal_address", address, 32'hBFC0_0004);
      chk("unal_byteenable", {28'd0, byteenable}, 32'h8);
      wait_rsp(n);
      chk("unal_rdata", rsp_rdata, 32'h2402_000A);
      gap_done();

      // back-to-back with req_valid held high
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr = 32'hBFC0_0008;
      req_byteenable = 4'hF;
      tick();
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("b2b_cycle%0d", i), {28'd0, read, write, rsp_valid, req_ready}, {28'd0, b2b_exp[i]});
         if (i < 5) tick();
      end
      req_valid = 1'b0;
      chk("b2b_rdata", rsp_rdata, 32'h0202_0202);

      // reset on the second stall cycle of a read
      wait_cfg = 5;
      issue(1'b0, 32'hBFC0_0004, 4'hF, 32'd0);
      tick();
      chk("rstmid_stall1", {30'd0, read, rsp_valid}, 32'd2);
      reset = 1'b1;
      tick();
      chk("rstmid_dropped", {29'd0, read, rsp_valid, req_ready}, 32'd0);
      reset = 1'b0;
      #1;
      chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
      tick();
      chk("rstmid_no_rsp", {30'd0, rsp_valid, req_ready}, 32'd1);

`ifdef AVM_TIMEOUT_EN
      // stuck responder
      saved = rsp_rdata;
      stuck = 1'b1;
      issue(1'b0, 32'hBFC0_0000, 4'hF, 32'd0);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("to_waiting", {30'd0, read, rsp_valid}, 32'd2);
      end
      tick();
      chk("to_abandon", {29'd0, read, rsp_valid, rsp_error}, 32'd3);
      chk("to_rdata_held", rsp_rdata, saved);
      stuck = 1'b0;
      gap_done();
      wait_cfg = 0;
      issue(1'b0, 32'hBFC0_0004, 4'hF, 32'd0);
      wait_rsp(n);
      chk("to_error_cleared", {31'd0, rsp_error}, 32'd0);
      chk("to_next_rdata", rsp_rdata, 32'h2402_000A);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/avalon_mm_master.md
Name: avalon_mm_master

Overview:
- Avalon-MM initiator between the CPU core's load/store/fetch request port and the word-addressed Avalon memory responder.
- Accepts one request at a time from the core and drives address, byteenable, read/write and writedata.
- Holds all bus outputs stable while waitrequest is high, then returns read data or a write acknowledge to the core.
- Inserts a mandatory idle cycle between transfers, because the responder starts a transfer on the rising edge of read/write.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles a transfer may stay in ACCESS; used only with AVM_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  core presents a request
- req_ready  output  1  master can accept a request this cycle
- req_write  input  1  1 = write, 0 = read
- req_addr  input  32  byte address
- req_byteenable  input  4  lane enables
- req_wdata  input  32  write data
- rsp_valid  output  1  one-cycle pulse: transfer completed
- rsp_rdata  output  32  read data; valid with rsp_valid on reads
- rsp_error  output  1  timeout flag; valid with rsp_valid; constant 0 without AVM_TIMEOUT_EN
- address  output  32  Avalon address, word aligned
- byteenable  output  4  Avalon byteenable
- read  output  1  Avalon read
- write  output  1  Avalon write
- writedata  output  32  Avalon writedata
- waitrequest  input  1  responder stall
- readdata  input  32  responder read data

Behaviour:
- Reset values: read=0, write=0, address=0, byteenable=0, writedata=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, state=IDLE.
- req_ready=1 only in IDLE; it is not asserted during reset.
- Handshake: the request is accepted on an edge where req_valid and req_ready are both 1. At that edge:
  - address <= {req_addr[31:2],2'b00}
  - byteenable, writedata and the direction are registered
  - read <= ~req_write, write <= req_write
  - state -> ACCESS
- ACCESS: address, byteenable, writedata, read and write stay constant.
  - The transfer completes on an edge where waitrequest=0.
  - At completion: rsp_valid <= 1, rsp_rdata <= readdata (reads only; unchanged on writes), read <= 0, write <= 0, state -> GAP.
  - A waitrequest that is 0 on the first ACCESS edge is legal and gives a one-cycle transfer.
- GAP: one cycle with read=write=0 and req_ready=0; rsp_valid returns to 0; state -> IDLE.
- read and write are never both 1.
- Minimum request-to-rsp_valid latency is 2 cycles: the accept edge, then the completion edge.
- Minimum back-to-back request spacing is 3 cycles.
- rsp_rdata holds its last value until the next read completes.
- req_* inputs are ignored outside the accept edge.
- Reset asserted mid-ACCESS:
  - read/write drop at that edge and the state returns to IDLE.
  - No rsp_valid is produced and the pending request is lost.
- waitrequest is ignored in IDLE and GAP.

Optional Feature:
- Macro: AVM_TIMEOUT_EN.
- With the macro defined, a counter clears on accept and increments each ACCESS cycle with waitrequest=1.
  - When the count reaches TIMEOUT_CYCLES-1 and waitrequest is still 1, the transfer is abandoned: read/write <= 0, rsp_valid <= 1, rsp_error <= 1, rsp_rdata unchanged, state -> GAP.
  - rsp_error clears on the next rsp_valid without a timeout.
- Without the macro: no counter, rsp_error is tied to 0, and ACCESS waits indefinitely.

Decomposition:
- Shared package avm_pkg holds:
  - state enum avm_state_t {IDLE, ACCESS, GAP}
  - AVM_ADDR_W=32, AVM_DATA_W=32, AVM_BE_W=4
- Sub-module avm_timeout_counter (counter plus expiry compare) is instantiated only under AVM_TIMEOUT_EN.

Test Plan:
- Read of 0xBFC00004 with responder wait of 0:
  - read=1 and address=0xBFC00004 one edge after accept
  - rsp_valid pulses with rsp_rdata equal to memory word 1 (e.g. 0x2402000A)
  - read is 0 in the following cycle
- Write 0xDEADBEEF to 0xBFC00010 with byteenable 4'b1111 and a 5-cycle waitrequest:
  - address, writedata and write stay stable for all 5 stall cycles
  - rsp_valid occurs 1 cycle after waitrequest falls
  - a following read of 0xBFC00010 returns 0xDEADBEEF
- Unaligned address 0xBFC00007 with byteenable 4'b1000: address=0xBFC00004 and byteenable=4'b1000 on the bus.
- Back-to-back requests with req_valid held high: read/write are 0 for at least 1 cycle between transfers, and req_ready is 0 during ACCESS and GAP.
- Reset asserted on the 2nd stall cycle of a read: read=0 at that edge, no rsp_valid, and req_ready=1 the cycle after reset deasserts.
- With AVM_TIMEOUT_EN, TIMEOUT_CYCLES=8 and waitrequest stuck at 1: rsp_valid=1 and rsp_error=1 after 8 ACCESS cycles, read drops, and the next normal read reports rsp_error=0.
